mem_if_unit: RTL and testbench

Memory interface unit of the TinyALU CPU. It accepts level-held load/store requests from the instruction unit and converts each one into byte transactions on an 8-bit, 14-bit-addressed main memory port. Load results come back on `data` with a one-cycle `mem_done` pulse. It sits between the instruction unit and main memory, as the responder end of the instruction unit's load/store protocol.

---
 rtl/tinyalu_pkg.sv | 22 ++
 rtl/mem_if_unit_if.sv | 33 +++
 rtl/mem_if_unit_timer.sv | 26 ++
 rtl/mem_if_unit.sv | 139 +++++++++++++
 tb/tb_mem_if_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types and widths; this slice adds the memory interface unit's
// state encoding and memory port widths.
package tinyalu_pkg;

  localparam int MIU_ADDR_W = 14;
  localparam int MIU_DATA_W = 8;
  localparam int MIU_WORD_W = 2 * MIU_DATA_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } miu_state_t;

  // Byte address of the high half of a 16-bit word; wraps at the top of memory.
  function automatic logic [MIU_ADDR_W-1:0] miu_next_addr(input logic [MIU_ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/mem_if_unit_if.sv
// Bus bundles for the memory interface unit: the instruction unit's load/store
// protocol and the byte-wide main memory port.
//
// Handshakes: load/store are level-held by the instruction unit until it sees the
// one-cycle mem_done pulse and must drop on that edge. mem_req stays high (with
// mem_we/mem_addr/mem_wdata stable) until mem_resp is sampled; mem_resp with
// mem_req low carries no meaning.
interface miu_ls_if;
  import tinyalu_pkg::*;
  logic                  load;
  logic                  store;
  logic [MIU_ADDR_W-1:0] addr;
  logic [MIU_WORD_W-1:0] result;
  logic [MIU_DATA_W-1:0] data;
  logic                  mem_done;
  logic                  err;

  modport master (output load, store, addr, result, input data, mem_done, err);
  modport slave  (input load, store, addr, result, output data, mem_done, err);
endinterface

interface miu_mem_if;
  import tinyalu_pkg::*;
  logic                  mem_req;
  logic                  mem_we;
  logic [MIU_ADDR_W-1:0] mem_addr;
  logic [MIU_DATA_W-1:0] mem_wdata;
  logic [MIU_DATA_W-1:0] mem_rdata;
  logic                  mem_resp;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_resp);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_resp);
endinterface

// File: rtl/mem_if_unit_timer.sv
// mem_if_timer: counts cycles a memory request has been outstanding.
// Only built when MIU_TIMEOUT_EN is defined.
`ifdef MIU_TIMEOUT_EN
module mem_if_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + 1'b1;
  end

  // Fires on the last permitted request cycle so mem_req is high for exactly TIMEOUT_CYCLES.
  assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/mem_if_unit.sv
// mem_if_unit: turns level-held load/store requests into byte transactions on the
// 14-bit-addressed memory port. Optional request timeout via MIU_TIMEOUT_EN.
module mem_if_unit
  import tinyalu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  miu_ls_if.slave    ls,
  miu_mem_if.master  mem,
  output miu_state_t o_dbg_state
);

  miu_state_t            r_state;
  logic [MIU_ADDR_W-1:0] r_addr;
  logic [MIU_WORD_W-1:0] r_result;
  logic [MIU_DATA_W-1:0] r_data;
  logic                  r_mem_done;
  logic                  r_err;
  logic                  r_timed_out;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [MIU_ADDR_W-1:0] r_mem_addr;
  logic [MIU_DATA_W-1:0] r_mem_wdata;

  logic w_resp_hit;
  logic w_expired;

  assign w_resp_hit = r_mem_req && mem.mem_resp;

`ifdef MIU_TIMEOUT_EN
  logic w_tmr_clr;

  // Every state change passes through one of these, so the count restarts per state.
  assign w_tmr_clr = (r_state == IDLE) || (r_state == DONE) || w_resp_hit || w_expired;

  mem_if_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_tmr_clr),
    .i_enable  (r_mem_req),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_result    <= '0;
      r_data      <= '0;
      r_mem_done  <= 1'b0;
      r_err       <= 1'b0;
      r_timed_out <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_done <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          // Store has priority when both requests are present.
          if (ls.store) begin
            r_addr      <= ls.addr;
            r_result    <= ls.result;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ls.addr;
            r_mem_wdata <= ls.result[MIU_DATA_W-1:0];
            r_state     <= WR_LO;
          end else if (ls.load) begin
            r_addr     <= ls.addr;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= ls.addr;
            r_state    <= READ;
          end
        end
        READ: begin
          if (w_resp_hit) begin
            r_data    <= mem.mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end else if (w_expired) begin
            r_mem_req   <= 1'b0;
            r_timed_out <= 1'b1;
            r_state     <= DONE;
          end
        end
        WR_LO: begin
          if (w_resp_hit) begin
            r_mem_addr  <= miu_next_addr(r_addr);
            r_mem_wdata <= r_result[MIU_WORD_W-1:MIU_DATA_W];
            r_state     <= WR_HI;
          end else if (w_expired) begin
            r_mem_req   <= 1'b0;
            r_timed_out <= 1'b1;
            r_state     <= DONE;
          end
        end
        WR_HI: begin
          if (w_resp_hit) begin
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end else if (w_expired) begin
            r_mem_req   <= 1'b0;
            r_timed_out <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_mem_done  <= 1'b1;
          r_err       <= r_timed_out;
          r_timed_out <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign ls.data       = r_data;
  assign ls.mem_done   = r_mem_done;
  assign ls.err        = r_err;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_if_unit.sv
// Directed bench for mem_if_unit: acts as instruction unit and byte memory,
// checks bus beats against an expected write queue and hand-computed results.
module tb_mem_if_unit;
  import tinyalu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  miu_ls_if   ls_bus();
  miu_mem_if  mem_bus();
  miu_state_t dbg_state;

  mem_if_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ls          (ls_bus),
    .mem         (mem_bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  int ticks    = 0;
  logic [21:0] exp_q[$];   // {addr, byte} of each expected write beat

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ticks++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic serve_beat(input bit we, input logic [13:0] a, input logic [7:0] rd, input int nwait);
    bit ok;
    logic [21:0] e;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_bus.mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("req_seen", {31'b0, ok}, 32'd1);
    if (!ok) return;
    check("mem_we", {31'b0, mem_bus.mem_we}, {31'b0, we});
    if (we) begin
      check("wq_avail", {31'b0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("wr_addr", {18'b0, mem_bus.mem_addr}, {18'b0, e[21:8]});
      check("wr_data", {24'b0, mem_bus.mem_wdata}, {24'b0, e[7:0]});
    end else begin
      check("rd_addr", {18'b0, mem_bus.mem_addr}, {18'b0, a});
    end
    repeat (nwait) tick();
    check("req_hold", {31'b0, mem_bus.mem_req}, 32'd1);
    mem_bus.mem_resp  = 1'b1;
    mem_bus.mem_rdata = rd;
    tick();
    mem_bus.mem_resp  = 1'b0;
    mem_bus.mem_rdata = 8'h00;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ls_bus.mem_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One complete load or store; latency counted from the driving negedge to mem_done.
  task automatic do_op(input bit ld, input bit st, input logic [13:0] a, input logic [15:0] r,
                       input logic [7:0] rd, input int w0, input int w1,
                       input logic [7:0] exp_data, input int exp_lat);
    int t0;
    bit ok;
    t0 = ticks;
    ls_bus.load   = ld;
    ls_bus.store  = st;
    ls_bus.addr   = a;
    ls_bus.result = r;
    if (st) begin
      exp_q.push_back({a, r[7:0]});
      exp_q.push_back({14'(a + 14'd1), r[15:8]});
    end
    serve_beat(st, a, rd, w0);
    ls_bus.addr   = ~a;
    ls_bus.result = ~r;
    if (st) serve_beat(1'b1, a, rd, w1);
    check("req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
    wait_done(ok);
    check("done_seen", {31'b0, ok}, 32'd1);
    check("latency", 32'(ticks - t0), 32'(exp_lat));
    check("data", {24'b0, ls_bus.data}, {24'b0, exp_data});
    check("err", {31'b0, ls_bus.err}, 32'd0);
    ls_bus.load  = 1'b0;
    ls_bus.store = 1'b0;
    tick();
    check("done_pulse", {31'b0, ls_bus.mem_done}, 32'd0);
    check("no_restart", {31'b0, mem_bus.mem_req}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ls_bus.load       = 1'b0;
    ls_bus.store      = 1'b0;
    ls_bus.addr       = '0;
    ls_bus.result     = '0;
    mem_bus.mem_resp  = 1'b0;
    mem_bus.mem_rdata = '0;

    tick();
    tick();
    check("rst_data",  {24'b0, ls_bus.data}, 32'd0);
    check("rst_done",  {31'b0, ls_bus.mem_done}, 32'd0);
    check("rst_err",   {31'b0, ls_bus.err}, 32'd0);
    check("rst_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_we",    {31'b0, mem_bus.mem_we}, 32'd0);
    check("rst_addr",  {18'b0, mem_bus.mem_addr}, 32'd0);
    check("rst_wdata", {24'b0, mem_bus.mem_wdata}, 32'd0);
    reset_n = 1'b1;
    tick();

    //      ld    st    addr      result    rdata  w0 w1 data   lat
    do_op(1'b1, 1'b0, 14'h0010, 16'h0000, 8'hA5, 3, 0, 8'hA5, 6);
    do_op(1'b1, 1'b0, 14'h1234, 16'h0000, 8'h3C, 0, 0, 8'h3C, 3);
    do_op(1'b0, 1'b1, 14'h0012, 16'hBEEF, 8'h00, 2, 1, 8'h3C, 7);
    do_op(1'b0, 1'b1, 14'h0100, 16'h5A6B, 8'h00, 0, 0, 8'h3C, 4);
    do_op(1'b0, 1'b1, 14'h3FFF, 16'h1234, 8'h00, 1, 0, 8'h3C, 5);
    do_op(1'b1, 1'b1, 14'h0020, 16'hCAFE, 8'h99, 0, 0, 8'h3C, 4);

    // mem_resp without mem_req must be ignored
    mem_bus.mem_resp  = 1'b1;
    mem_bus.mem_rdata = 8'hEE;
    tick();
    tick();
    mem_bus.mem_resp  = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    check("spur_req",  {31'b0, mem_bus.mem_req}, 32'd0);
    check("spur_done", {31'b0, ls_bus.mem_done}, 32'd0);
    check("spur_data", {24'b0, ls_bus.data}, 32'h3C);
    check("spur_state", 32'(dbg_state), 32'(IDLE));
    tick();

    // reset while the high byte is being written
    ls_bus.store  = 1'b1;
    ls_bus.addr   = 14'h0040;
    ls_bus.result = 16'h1111;
    exp_q.push_back({14'h0040, 8'h11});
    serve_beat(1'b1, 14'h0040, 8'h00, 0);
    check("wrhi_req",  {31'b0, mem_bus.mem_req}, 32'd1);
    check("wrhi_addr", {18'b0, mem_bus.mem_addr}, 32'h0041);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    check("mrst_we",    {31'b0, mem_bus.mem_we}, 32'd0);
    check("mrst_addr",  {18'b0, mem_bus.mem_addr}, 32'd0);
    check("mrst_wdata", {24'b0, mem_bus.mem_wdata}, 32'd0);
    check("mrst_data",  {24'b0, ls_bus.data}, 32'd0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    ls_bus.store = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_nodone", {31'b0, ls_bus.mem_done}, 32'd0);
    end
    reset_n = 1'b1;
    tick();
    do_op(1'b1, 1'b0, 14'h0050, 16'h0000, 8'h77, 2, 0, 8'h77, 5);

`ifdef MIU_TIMEOUT_EN
    begin
      int  n_hi;
      bit  ok;
      ls_bus.load = 1'b1;
      ls_bus.addr = 14'h0030;
      tick();
      n_hi = 0;
      while (mem_bus.mem_req && n_hi < 30) begin
        tick();
        n_hi++;
      end
      check("to_req_cycles", 32'(n_hi), 32'd8);
      wait_done(ok);
      check("to_done_seen", {31'b0, ok}, 32'd1);
      check("to_err", {31'b0, ls_bus.err}, 32'd1);
      check("to_data", {24'b0, ls_bus.data}, 32'h77);
      ls_bus.load = 1'b0;
      tick();
      check("to_err_clear", {31'b0, ls_bus.err}, 32'd0);
      check("to_done_pulse", {31'b0, ls_bus.mem_done}, 32'd0);
    end
`endif

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
